// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared state encodings and default sizing for the register file
package risc_pkg;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_NUM_REGS = 32;
    localparam int DEFAULT_NUM_RD   = 2;

    // Controller states: clear sweep after reset, normal operation, register dump stream
    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_DUMP = 2'd2;

endpackage

// File: rtl/risc_regfile_rdport.sv
// rtl/risc_regfile_rdport.sv - one read port: storage mux, zero-register masking, optional write bypass (REGFILE_BYPASS_EN)
module risc_regfile_rdport
    import risc_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                         en,
    input  logic [AW-1:0]                addr,
    input  logic [NUM_REGS*DATA_W-1:0]   regs_flat,
`ifdef REGFILE_BYPASS_EN
    input  logic                         byp_en,
    input  logic [AW-1:0]                byp_addr,
    input  logic [DATA_W-1:0]            byp_data,
`endif
    output logic [DATA_W-1:0]            data
);

    // Reads return zero while the file is not ready and for a hard-wired register 0
    always_comb begin
        data = '0;
        if (en && !(ZERO_REG != 0 && addr == '0)) begin
            data = regs_flat[int'(addr) * DATA_W +: DATA_W];
`ifdef REGFILE_BYPASS_EN
            // byp_en already excludes discarded writes, so forwarding is always safe here
            if (byp_en && byp_addr == addr) begin
                data = byp_data;
            end
`endif
        end
    end

endmodule

// File: rtl/risc_regfile.sv
// rtl/risc_regfile.sv - multi-read register file with init sweep and dump stream; optional REGFILE_BYPASS_EN
module risc_regfile
    import risc_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int NUM_RD   = DEFAULT_NUM_RD,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     ready,
    input  logic                     dump_start,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [AW-1:0]            dump_idx,
    output logic [DATA_W-1:0]        dump_data,
    output logic                     dump_last,
    output logic                     busy
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    logic [1:0]                   state;
    logic [AW-1:0]                sweep;
    logic [AW-1:0]                idx;
    logic [DATA_W-1:0]            regs [NUM_REGS];
    logic [NUM_REGS*DATA_W-1:0]   regs_flat;
    logic                         wr_fire;

    // Outputs are masked by reset too so a held reset looks like INIT even before the first edge
    assign ready      = !reset && state != ST_INIT;
    assign busy       = reset || state != ST_IDLE;
    assign dump_valid = !reset && state == ST_DUMP;
    assign dump_idx   = dump_valid ? idx : '0;
    assign dump_data  = dump_valid ? regs[idx] : '0;
    assign dump_last  = dump_valid && idx == LAST_IDX;
    assign wr_fire    = wr_en && ready && !(ZERO_REG != 0 && wr_addr == '0);

    // Controller: INIT sweep, IDLE, and DUMP index advance on each accepted beat
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
            sweep <= '0;
            idx   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    sweep <= sweep + 1'b1;
                    if (sweep == LAST_IDX) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (dump_start) begin
                        state <= ST_DUMP;
                        idx   <= '0;
                    end
                end
                ST_DUMP: begin
                    if (dump_ready) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_IDLE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_INIT;
                    sweep <= '0;
                end
            endcase
        end
    end

    // Storage: the sweep owns the array during INIT, otherwise the single write port does
    always_ff @(posedge clk) begin
        if (!reset && state == ST_INIT) begin
            regs[sweep] <= '0;
        end else if (wr_fire) begin
            regs[wr_addr] <= wr_data;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
        end

        for (g = 0; g < NUM_RD; g++) begin : g_rd
            risc_regfile_rdport #(
                .DATA_W   (DATA_W),
                .NUM_REGS (NUM_REGS),
                .ZERO_REG (ZERO_REG)
            ) u_rdport (
                .en        (ready),
                .addr      (rd_addr[g*AW +: AW]),
                .regs_flat (regs_flat),
`ifdef REGFILE_BYPASS_EN
                .byp_en    (wr_fire),
                .byp_addr  (wr_addr),
                .byp_data  (wr_data),
`endif
                .data      (rd_data[g*DATA_W +: DATA_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_risc_regfile.sv
// tb/tb_risc_regfile.sv - scoreboard bench for risc_regfile
module tb_risc_regfile;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int AW  = 5;
    localparam int ZR  = 1;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              ready;
    logic              dump_start;
    logic              dump_valid;
    logic              dump_ready;
    logic [AW-1:0]     dump_idx;
    logic [DW-1:0]     dump_data;
    logic              dump_last;
    logic              busy;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0]    rd_q[$];
    logic [AW+DW:0]   dump_q[$];

    always #5 clk = ~clk;

    risc_regfile #(
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .NUM_RD   (NRD),
        .ZERO_REG (ZR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .ready      (ready),
        .dump_start (dump_start),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .busy       (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; dump_start = 1'b0; dump_ready = 1'b0;
        step();
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
        total++; if (dump_valid !== 1'b0) begin bad++; $display("FAIL reset_dump_valid got=%b exp=0", dump_valid); end
        total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        step();
        reset = 1'b0;
    endtask

    // Counts edges until ready after reset release while hammering wr_en, then checks all zero
    task automatic test_init_sweep();
        int n = 0;
        logic [DW-1:0] e;
        while (n < 100) begin
            wr_en = 1'b1; wr_addr = AW'(n + 1); wr_data = 32'hDEAD_BEEF;
            step();
            n++;
            if (ready === 1'b1) break;
        end
        wr_en = 1'b0;
        total++; if (n !== NR) begin bad++; $display("FAIL init_len got=%0d exp=%0d", n, NR); end
        for (int i = 0; i < NR; i++) begin
            rd_addr = {AW'(NR - 1 - i), AW'(i)};
            rd_q.push_back('0); rd_q.push_back('0);
            @(negedge clk);
            e = rd_q.pop_front();
            total++; if (rd_data[DW-1:0] !== e) begin bad++; $display("FAIL init_zero_p0 r%0d got=%h exp=%h", i, rd_data[DW-1:0], e); end
            e = rd_q.pop_front();
            total++; if (rd_data[2*DW-1:DW] !== e) begin bad++; $display("FAIL init_zero_p1 r%0d got=%h exp=%h", NR - 1 - i, rd_data[2*DW-1:DW], e); end
            step();
        end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] e;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'd100;
        step();
        wr_data = 32'd7;
        step();
        wr_en = 1'b0;
        rd_addr = {5'd5, 5'd5};
        rd_q.push_back(32'd7); rd_q.push_back(32'd7);
        @(negedge clk);
        e = rd_q.pop_front();
        total++; if (rd_data[DW-1:0] !== e) begin bad++; $display("FAIL r5_p0 got=%0d exp=%0d", rd_data[DW-1:0], e); end
        e = rd_q.pop_front();
        total++; if (rd_data[2*DW-1:DW] !== e) begin bad++; $display("FAIL r5_p1 got=%0d exp=%0d", rd_data[2*DW-1:DW], e); end
        step();
    endtask

    task automatic test_zero_reg();
        logic [DW-1:0] e;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'd55;
        step();
        wr_en = 1'b0;
        rd_addr = {5'd0, 5'd0};
        rd_q.push_back(ZR != 0 ? 32'd0 : 32'd55); rd_q.push_back(ZR != 0 ? 32'd0 : 32'd55);
        @(negedge clk);
        e = rd_q.pop_front();
        total++; if (rd_data[DW-1:0] !== e) begin bad++; $display("FAIL r0_p0 got=%0d exp=%0d", rd_data[DW-1:0], e); end
        e = rd_q.pop_front();
        total++; if (rd_data[2*DW-1:DW] !== e) begin bad++; $display("FAIL r0_p1 got=%0d exp=%0d", rd_data[2*DW-1:DW], e); end
        step();
    endtask

    task automatic test_bypass();
        logic [DW-1:0] e;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd9;
        rd_addr = {5'd3, 5'd3};
        rd_q.push_back(BYP ? 32'd9 : 32'd0); rd_q.push_back(BYP ? 32'd9 : 32'd0);
        @(negedge clk);
        e = rd_q.pop_front();
        total++; if (rd_data[DW-1:0] !== e) begin bad++; $display("FAIL byp_same_p0 got=%0d exp=%0d", rd_data[DW-1:0], e); end
        e = rd_q.pop_front();
        total++; if (rd_data[2*DW-1:DW] !== e) begin bad++; $display("FAIL byp_same_p1 got=%0d exp=%0d", rd_data[2*DW-1:DW], e); end
        step();
        wr_en = 1'b0;
        rd_q.push_back(32'd9); rd_q.push_back(32'd9);
        @(negedge clk);
        e = rd_q.pop_front();
        total++; if (rd_data[DW-1:0] !== e) begin bad++; $display("FAIL byp_next_p0 got=%0d exp=%0d", rd_data[DW-1:0], e); end
        e = rd_q.pop_front();
        total++; if (rd_data[2*DW-1:DW] !== e) begin bad++; $display("FAIL byp_next_p1 got=%0d exp=%0d", rd_data[2*DW-1:DW], e); end
        step();
    endtask

    task automatic load_regs();
        for (int n = 0; n < NR; n++) begin
            wr_en = 1'b1; wr_addr = AW'(n); wr_data = DW'(n);
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_dump();
        logic [AW+DW:0] e;
        int cyc = 0;
        load_regs();
        for (int n = 0; n < NR; n++) begin
            dump_q.push_back({(n == NR - 1), AW'(n), DW'(n)});
        end
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        while (dump_q.size() > 0 && cyc < 200) begin
            dump_ready = cyc[0];
            @(negedge clk);
            if (dump_valid && dump_ready) begin
                e = dump_q.pop_front();
                total++;
                if ({dump_last, dump_idx, dump_data} !== e) begin
                    bad++;
                    $display("FAIL dump_beat got=%b/%0d/%0d exp=%b/%0d/%0d", dump_last, dump_idx, dump_data, e[AW+DW], e[AW+DW-1:DW], e[DW-1:0]);
                end
            end else begin
                e = dump_q[0];
                total++;
                if ({dump_valid, dump_last, dump_idx, dump_data} !== {1'b1, e}) begin
                    bad++;
                    $display("FAIL dump_hold got=%b/%b/%0d/%0d exp=1/%b/%0d/%0d", dump_valid, dump_last, dump_idx, dump_data, e[AW+DW], e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
            step();
            cyc++;
        end
        dump_ready = 1'b0;
        total++; if (dump_q.size() != 0) begin bad++; $display("FAIL dump_timeout got=%0d_left exp=0", dump_q.size()); end
        total++; if ({busy, dump_valid, dump_last} !== 3'b000) begin bad++; $display("FAIL dump_end_idle got=%b exp=000", {busy, dump_valid, dump_last}); end
        dump_q.delete();
    endtask

    task automatic test_reset_mid_dump();
        logic [DW-1:0] e;
        int n = 0;
        bit hit = 1'b0;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (dump_valid && dump_idx == 5'd10) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        total++; if (hit !== 1'b1) begin bad++; $display("FAIL abort_reach_idx10 got=%b exp=1", hit); end
        reset = 1'b1;
        step();
        dump_ready = 1'b0;
        total++; if ({dump_valid, busy, ready} !== 3'b010) begin bad++; $display("FAIL abort_state got=%b exp=010", {dump_valid, busy, ready}); end
        reset = 1'b0;
        while (n < 100) begin
            step();
            n++;
            if (ready === 1'b1) break;
        end
        total++; if (n !== NR) begin bad++; $display("FAIL abort_init_len got=%0d exp=%0d", n, NR); end
        for (int i = 0; i < NR; i++) begin
            rd_addr = {AW'(i), AW'(NR - 1 - i)};
            rd_q.push_back('0); rd_q.push_back('0);
            @(negedge clk);
            e = rd_q.pop_front();
            total++; if (rd_data[DW-1:0] !== e) begin bad++; $display("FAIL abort_zero_p0 r%0d got=%h exp=%h", NR - 1 - i, rd_data[DW-1:0], e); end
            e = rd_q.pop_front();
            total++; if (rd_data[2*DW-1:DW] !== e) begin bad++; $display("FAIL abort_zero_p1 r%0d got=%h exp=%h", i, rd_data[2*DW-1:DW], e); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_dump();
        test_reset_mid_dump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
